pc_sequencer: RTL

- Parametrised next-generation program counter for the pipelined CPU fetch stage.
- Holds the PC, generates PC+1 internally and accepts relative branch, absolute jump, call and return commands.
- Keeps a small return-address stack (RAS) and a sticky HALT state that only an explicit resume or reset releases.
- Sits between the decode/branch-resolution logic and the instruction memory address port.

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between decode/branch resolution and the PC sequencer.
// Sequencer outputs are registered; commands take effect on the next rising clock edge.
interface pc_sequencer_if #(
    parameter int PC_W      = 11,
    parameter int OFF_W     = 11,
    parameter int RAS_PTR_W = 2
);
    logic                 i_enable;
    logic [2:0]           i_op;
    logic [OFF_W-1:0]     i_offset;
    logic [PC_W-1:0]      i_target;
    logic                 i_resume;
    logic [PC_W-1:0]      o_pc;
    logic                 o_halted;
    logic [RAS_PTR_W:0]   o_ras_cnt;
    logic                 o_ras_err;

    modport master (
        output i_enable, i_op, i_offset, i_target, i_resume,
        input  o_pc, o_halted, o_ras_cnt, o_ras_err
    );

    modport slave (
        input  i_enable, i_op, i_offset, i_target, i_resume,
        output o_pc, o_halted, o_ras_cnt, o_ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: SEQ/BRANCH/JUMP/CALL/RET/HALT with return-address stack.
// Latency: one cycle, command at edge N is visible on o_pc after edge N.
// Backpressure: i_enable=0 stalls PC and RAS; HALTED ignores commands until i_resume.
module pc_sequencer #(
    parameter int              PC_W      = 11,
    parameter int              OFF_W     = 11,
    parameter int              RAS_PTR_W = 2,
    parameter logic [PC_W-1:0] PC_RST    = '0
) (
    input logic          i_clk,
    input logic          i_rst,
    pc_sequencer_if.slave bus
);

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    localparam int                 RAS_DEPTH = 1 << RAS_PTR_W;
    localparam logic [RAS_PTR_W:0] RAS_FULL  = (RAS_PTR_W+1)'(RAS_DEPTH);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic               halted_q;
    logic [RAS_PTR_W:0] ras_cnt_q;
    logic               ras_err_q;
    logic [PC_W-1:0]    ras_q [RAS_DEPTH];

    logic [OFF_W-1:0]     offset_raw;
    logic [PC_W-1:0]      offset_ext;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      pc_branch;
    logic                 ras_full;
    logic                 ras_empty;
    logic [RAS_PTR_W-1:0] push_idx;
    logic [RAS_PTR_W-1:0] top_idx;
    logic                 do_push;

    // Wrapping arithmetic falls out of the fixed PC_W width.
    assign offset_raw = bus.i_offset;
    assign offset_ext = PC_W'($signed(offset_raw));
    assign pc_inc     = pc_q + 1'b1;
    assign pc_branch  = pc_q + offset_ext;

    assign ras_full  = (ras_cnt_q == RAS_FULL);
    assign ras_empty = (ras_cnt_q == '0);
    assign push_idx  = ras_cnt_q[RAS_PTR_W-1:0];
    assign top_idx   = RAS_PTR_W'(ras_cnt_q - 1'b1);

    assign do_push = !i_rst && (state_q == S_RUN) && bus.i_enable
                     && (bus.i_op == OP_CALL) && !ras_full;

    // Stack storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            ras_q[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            pc_q      <= PC_RST;
            halted_q  <= 1'b0;
            ras_cnt_q <= '0;
            ras_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.i_enable) begin
                        case (bus.i_op)
                            OP_SEQ:    pc_q <= pc_inc;
                            OP_BRANCH: pc_q <= pc_branch;
                            OP_JUMP:   pc_q <= bus.i_target;
                            OP_CALL: begin
                                pc_q <= bus.i_target;
                                if (ras_full) begin
                                    ras_err_q <= 1'b1;
                                end else begin
                                    ras_cnt_q <= ras_cnt_q + 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (ras_empty) begin
                                    pc_q      <= pc_inc;
                                    ras_err_q <= 1'b1;
                                end else begin
                                    pc_q      <= ras_q[top_idx];
                                    ras_cnt_q <= ras_cnt_q - 1'b1;
                                end
                            end
                            OP_HALT: begin
                                // PC stays on the HALT instruction itself.
                                state_q  <= S_HALTED;
                                halted_q <= 1'b1;
                            end
                            default:   pc_q <= pc_inc;
                        endcase
                    end
                end
                S_HALTED: begin
                    if (bus.i_resume) begin
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                        pc_q     <= pc_inc;
                    end
                end
                default: begin
                    state_q  <= S_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pc      = pc_q;
    assign bus.o_halted  = halted_q;
    assign bus.o_ras_cnt = ras_cnt_q;
    assign bus.o_ras_err = ras_err_q;

endmodule
